// File: rtl/branch_predictor_if.sv
// Fetch/EX-side bundle of the branch predictor.
// Pipeline drives as master; the predictor is the slave.
interface branch_predictor_if #(
  parameter int PHT_IDX_W = 6
);
  logic [31:0]          IF_pc;
  logic                 IF_btb_b_hit;
  logic                 IF_btb_j_hit;
  logic [31:0]          IF_btb_target;
  logic                 IF_gbc_predict_taken;
  logic [PHT_IDX_W-1:0] IF_pht_idx;
  logic                 EX_is_branch;
  logic                 EX_is_jal;
  logic [31:0]          EX_pc;
  logic [31:0]          EX_target;
  logic                 EX_actual_taken;
  logic                 EX_predict_taken;
  logic [PHT_IDX_W-1:0] EX_pht_idx;
  logic [31:0]          perf_branch_cnt;
  logic [31:0]          perf_mispredict_cnt;

  modport master (
    output IF_pc,
    output EX_is_branch,
    output EX_is_jal,
    output EX_pc,
    output EX_target,
    output EX_actual_taken,
    output EX_predict_taken,
    output EX_pht_idx,
    input  IF_btb_b_hit,
    input  IF_btb_j_hit,
    input  IF_btb_target,
    input  IF_gbc_predict_taken,
    input  IF_pht_idx,
    input  perf_branch_cnt,
    input  perf_mispredict_cnt
  );

  modport slave (
    input  IF_pc,
    input  EX_is_branch,
    input  EX_is_jal,
    input  EX_pc,
    input  EX_target,
    input  EX_actual_taken,
    input  EX_predict_taken,
    input  EX_pht_idx,
    output IF_btb_b_hit,
    output IF_btb_j_hit,
    output IF_btb_target,
    output IF_gbc_predict_taken,
    output IF_pht_idx,
    output perf_branch_cnt,
    output perf_mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: direct-mapped BTB plus gshare PHT.
// Trained non-speculatively from resolved EX-stage branches/JALs.
module branch_predictor #(
  parameter int BTB_IDX_W = 4,
  parameter int PHT_IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  branch_predictor_if.slave bp
);

  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int TAG_W = 32 - BTB_IDX_W - 2;

  logic [BTB_N-1:0] btb_vld;
  logic [BTB_N-1:0] btb_jal;
  logic [TAG_W-1:0] btb_tag [BTB_N];
  logic [31:0]      btb_tgt [BTB_N];
  logic [1:0]       pht     [PHT_N];
  logic [PHT_IDX_W-1:0] ghr;

  logic [BTB_IDX_W-1:0] if_idx;
  logic [TAG_W-1:0]     if_tag;
  logic                 if_hit;
  logic [PHT_IDX_W-1:0] if_pht_idx;

  logic [BTB_IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0]     ex_tag;
  logic                 btb_we;
  logic                 btb_we_jal;
  logic                 pht_we;
  logic [1:0]           pht_cur;
  logic [1:0]           pht_nxt;

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{bp.IF_pc[1:0], bp.EX_pc[1:0]};

  assign if_idx = bp.IF_pc[BTB_IDX_W+1:2];
  assign if_tag = bp.IF_pc[31:BTB_IDX_W+2];
  assign ex_idx = bp.EX_pc[BTB_IDX_W+1:2];
  assign ex_tag = bp.EX_pc[31:BTB_IDX_W+2];

  assign if_pht_idx = bp.IF_pc[PHT_IDX_W+1:2] ^ ghr;

  // Combinational BTB/PHT lookup against pre-update contents
  always_comb begin
    if_hit = btb_vld[if_idx] && (btb_tag[if_idx] == if_tag);
    bp.IF_btb_b_hit = if_hit && !btb_jal[if_idx];
    bp.IF_btb_j_hit = if_hit && btb_jal[if_idx];
    bp.IF_btb_target = if_hit ? btb_tgt[if_idx] : 32'd0;
    bp.IF_pht_idx = if_pht_idx;
    bp.IF_gbc_predict_taken = pht[if_pht_idx][1];
  end

  // Decode EX resolution into write enables; branch wins over JAL
  always_comb begin
    btb_we     = 1'b0;
    btb_we_jal = 1'b0;
    pht_we     = 1'b0;
    priority case (1'b1)
      bp.EX_is_branch: begin
        btb_we = bp.EX_actual_taken;
        pht_we = 1'b1;
      end
      bp.EX_is_jal: begin
        btb_we     = 1'b1;
        btb_we_jal = 1'b1;
      end
      default: ;
    endcase
  end

  // Saturating 2-bit counter step
  always_comb begin
    pht_cur = pht[bp.EX_pht_idx];
    pht_nxt = pht_cur;
    if (bp.EX_actual_taken) begin
      if (pht_cur != 2'b11) pht_nxt = pht_cur + 2'd1;
    end else begin
      if (pht_cur != 2'b00) pht_nxt = pht_cur - 2'd1;
    end
  end

  // BTB fill; taken branches and JALs replace any alias
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_vld <= '0;
      btb_jal <= '0;
      for (int i = 0; i < BTB_N; i++) begin
        btb_tag[i] <= '0;
        btb_tgt[i] <= '0;
      end
    end else if (btb_we) begin
      btb_vld[ex_idx] <= 1'b1;
      btb_jal[ex_idx] <= btb_we_jal;
      btb_tag[ex_idx] <= ex_tag;
      btb_tgt[ex_idx] <= bp.EX_target;
    end
  end

  // PHT counters train on every resolved branch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
    end else if (pht_we) begin
      pht[bp.EX_pht_idx] <= pht_nxt;
    end
  end

  // Global history shifts in resolved outcomes only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (pht_we) begin
      ghr <= {ghr[PHT_IDX_W-2:0], bp.EX_actual_taken};
    end
  end

  // Branch and mispredict performance counters (wrap at 2^32)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp.perf_branch_cnt     <= '0;
      bp.perf_mispredict_cnt <= '0;
    end else if (pht_we) begin
      bp.perf_branch_cnt <= bp.perf_branch_cnt + 32'd1;
      if (bp.EX_predict_taken != bp.EX_actual_taken)
        bp.perf_mispredict_cnt <= bp.perf_mispredict_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor.
// Expected values are hand-computed constants.
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  branch_predictor_if bp_if ();

  branch_predictor dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ex_clear();
    bp_if.EX_is_branch     = 1'b0;
    bp_if.EX_is_jal        = 1'b0;
    bp_if.EX_pc            = '0;
    bp_if.EX_target        = '0;
    bp_if.EX_actual_taken  = 1'b0;
    bp_if.EX_predict_taken = 1'b0;
    bp_if.EX_pht_idx       = '0;
  endtask

  task automatic ex_drive(input logic br, input logic jal,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic tk, input logic pr,
                          input logic [5:0] idx);
    bp_if.EX_is_branch     = br;
    bp_if.EX_is_jal        = jal;
    bp_if.EX_pc            = pc;
    bp_if.EX_target        = tgt;
    bp_if.EX_actual_taken  = tk;
    bp_if.EX_predict_taken = pr;
    bp_if.EX_pht_idx       = idx;
  endtask

  task automatic ex_branch(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic pr,
                           input logic [5:0] idx);
    @(negedge clk);
    ex_drive(1'b1, 1'b0, pc, tgt, tk, pr, idx);
    @(posedge clk);
    #1 ex_clear();
  endtask

  task automatic ex_jal(input logic [31:0] pc, input logic [31:0] tgt);
    @(negedge clk);
    ex_drive(1'b0, 1'b1, pc, tgt, 1'b0, 1'b0, 6'h00);
    @(posedge clk);
    #1 ex_clear();
  endtask

  task automatic look(input logic [31:0] pc);
    @(negedge clk);
    bp_if.IF_pc = pc;
    #1;
  endtask

  initial begin
    ex_clear();
    bp_if.IF_pc = 32'h100;
    #12;
    chk("rst_bhit", bp_if.IF_btb_b_hit, 1'b0);
    chk("rst_jhit", bp_if.IF_btb_j_hit, 1'b0);
    chk("rst_tgt", bp_if.IF_btb_target, 32'h0);
    chk("rst_pred", bp_if.IF_gbc_predict_taken, 1'b0);
    chk("rst_idx", bp_if.IF_pht_idx, 6'h00);
    chk("rst_brc", bp_if.perf_branch_cnt, 32'd0);
    chk("rst_mpc", bp_if.perf_mispredict_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // taken branch 0x100 -> 0x80, predicted not-taken
    ex_branch(32'h100, 32'h80, 1'b1, 1'b0, 6'h00);
    look(32'h100);
    chk("b1_bhit", bp_if.IF_btb_b_hit, 1'b1);
    chk("b1_jhit", bp_if.IF_btb_j_hit, 1'b0);
    chk("b1_tgt", bp_if.IF_btb_target, 32'h80);
    chk("b1_idx", bp_if.IF_pht_idx, 6'h01);
    chk("b1_pred", bp_if.IF_gbc_predict_taken, 1'b0);
    look(32'h4);
    chk("b1_pht0", bp_if.IF_gbc_predict_taken, 1'b1);
    chk("b1_brc", bp_if.perf_branch_cnt, 32'd1);
    chk("b1_mpc", bp_if.perf_mispredict_cnt, 32'd1);

    // PHT[5]: four taken then one not-taken; lookups index 5
    ex_branch(32'h304, 32'h310, 1'b1, 1'b1, 6'h05);
    look(32'h18);
    chk("s1_idx", bp_if.IF_pht_idx, 6'h05);
    chk("s1_pred", bp_if.IF_gbc_predict_taken, 1'b1);
    ex_branch(32'h304, 32'h310, 1'b1, 1'b1, 6'h05);
    look(32'h08);
    chk("s2_pred", bp_if.IF_gbc_predict_taken, 1'b1);
    ex_branch(32'h304, 32'h310, 1'b1, 1'b1, 6'h05);
    look(32'h28);
    chk("s3_pred", bp_if.IF_gbc_predict_taken, 1'b1);
    ex_branch(32'h304, 32'h310, 1'b1, 1'b1, 6'h05);
    look(32'h68);
    chk("s4_pred", bp_if.IF_gbc_predict_taken, 1'b1);
    ex_branch(32'h304, 32'h310, 1'b0, 1'b1, 6'h05);
    look(32'hEC);
    chk("s5_idx", bp_if.IF_pht_idx, 6'h05);
    chk("s5_pred", bp_if.IF_gbc_predict_taken, 1'b1);
    look(32'h0);
    chk("s5_ghr", bp_if.IF_pht_idx, 6'h3E);

    // JAL 0x200 -> 0x400
    ex_jal(32'h200, 32'h400);
    look(32'h200);
    chk("j_jhit", bp_if.IF_btb_j_hit, 1'b1);
    chk("j_bhit", bp_if.IF_btb_b_hit, 1'b0);
    chk("j_tgt", bp_if.IF_btb_target, 32'h400);
    look(32'h0);
    chk("j_ghr", bp_if.IF_pht_idx, 6'h3E);
    chk("j_brc", bp_if.perf_branch_cnt, 32'd6);
    chk("j_mpc", bp_if.perf_mispredict_cnt, 32'd2);

    // alias at BTB index 0
    ex_branch(32'h100, 32'h80, 1'b1, 1'b0, 6'h0A);
    look(32'h100);
    chk("a1_bhit", bp_if.IF_btb_b_hit, 1'b1);
    chk("a1_tgt", bp_if.IF_btb_target, 32'h80);
    @(negedge clk);
    ex_drive(1'b1, 1'b0, 32'h140, 32'hC0, 1'b1, 1'b0, 6'h0A);
    bp_if.IF_pc = 32'h100;
    #1;
    chk("a_same_tgt", bp_if.IF_btb_target, 32'h80);
    @(posedge clk);
    #1 ex_clear();
    look(32'h100);
    chk("a_old_hit", bp_if.IF_btb_b_hit, 1'b0);
    chk("a_old_tgt", bp_if.IF_btb_target, 32'h0);
    look(32'h140);
    chk("a_new_hit", bp_if.IF_btb_b_hit, 1'b1);
    chk("a_new_tgt", bp_if.IF_btb_target, 32'hC0);
    chk("a_brc", bp_if.perf_branch_cnt, 32'd8);
    chk("a_mpc", bp_if.perf_mispredict_cnt, 32'd4);

    // clean reset, then eight branches with three mispredicts
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ex_branch(32'h600, 32'h700, 1'b0, 1'b0, 6'h07);
    ex_branch(32'h600, 32'h700, 1'b1, 1'b1, 6'h07);
    ex_branch(32'h600, 32'h700, 1'b1, 1'b0, 6'h07);
    ex_branch(32'h600, 32'h700, 1'b0, 1'b1, 6'h07);
    ex_branch(32'h600, 32'h700, 1'b1, 1'b1, 6'h07);
    ex_branch(32'h600, 32'h700, 1'b0, 1'b0, 6'h07);
    ex_branch(32'h600, 32'h700, 1'b1, 1'b0, 6'h07);
    ex_branch(32'h600, 32'h700, 1'b1, 1'b1, 6'h07);
    look(32'h600);
    chk("p_brc", bp_if.perf_branch_cnt, 32'd8);
    chk("p_mpc", bp_if.perf_mispredict_cnt, 32'd3);
    chk("p_hit", bp_if.IF_btb_b_hit, 1'b1);

    // reset lands with an update pending
    @(negedge clk);
    ex_drive(1'b1, 1'b0, 32'h500, 32'h600, 1'b1, 1'b0, 6'h00);
    rst = 1'b0;
    #1;
    chk("r_async_brc", bp_if.perf_branch_cnt, 32'd0);
    @(posedge clk);
    #1;
    chk("r_brc", bp_if.perf_branch_cnt, 32'd0);
    chk("r_mpc", bp_if.perf_mispredict_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ex_clear();
    look(32'h500);
    chk("r_pend_hit", bp_if.IF_btb_b_hit, 1'b0);
    chk("r_pend_tgt", bp_if.IF_btb_target, 32'h0);
    look(32'h600);
    chk("r_old_hit", bp_if.IF_btb_b_hit, 1'b0);
    look(32'h0);
    chk("r_ghr", bp_if.IF_pht_idx, 6'h00);
    chk("r_pht0", bp_if.IF_gbc_predict_taken, 1'b0);
    look(32'h1C);
    chk("r_pht7", bp_if.IF_gbc_predict_taken, 1'b0);
    look(32'h0);
    chk("r_post_brc", bp_if.perf_branch_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage branch prediction unit for the RV32 five-stage pipeline.
- Holds a direct-mapped BTB and a gshare pattern history table (PHT) of 2-bit saturating counters. Both are indexed combinationally from IF_pc.
- Supplies IF_btb_b_hit, IF_btb_j_hit, IF_btb_target and IF_gbc_predict_taken to the pipeline controller and PC mux.
- Trains on resolved branch and JAL information from the EX stage, and keeps branch/mispredict performance counters.

Parameters:
- BTB_IDX_W, 4, log2 of BTB entry count (16 entries)
- PHT_IDX_W, 6, log2 of PHT entry count; also the global history register (GHR) width

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- IF_pc  input  32  fetch PC
- IF_btb_b_hit  output  1  BTB hit on a conditional-branch entry
- IF_btb_j_hit  output  1  BTB hit on a JAL entry
- IF_btb_target  output  32  predicted target of the hitting entry; 0 on miss
- IF_gbc_predict_taken  output  1  MSB of the indexed PHT counter
- IF_pht_idx  output  PHT_IDX_W  PHT index used for this fetch; travels down the pipeline with the instruction
- EX_is_branch  input  1  EX holds a B-type instruction (a bubble or flush gives 0)
- EX_is_jal  input  1  EX holds a JAL
- EX_pc  input  32  PC of the EX instruction
- EX_target  input  32  computed taken target (pc + imm)
- EX_actual_taken  input  1  resolved branch outcome
- EX_predict_taken  input  1  prediction carried with the instruction (gbc_predict_taken AND btb_b_hit)
- EX_pht_idx  input  PHT_IDX_W  IF_pht_idx carried to EX
- perf_branch_cnt  output  32  resolved B-type count
- perf_mispredict_cnt  output  32  B-type mispredict count

Behaviour:
- BTB entry fields: valid, tag = pc[31:BTB_IDX_W+2], target[31:0], type (0 = branch, 1 = JAL). Entry index = pc[BTB_IDX_W+1:2].
- Lookup is combinational. A hit requires valid and a tag match.
  - IF_btb_b_hit = hit AND type == 0.
  - IF_btb_j_hit = hit AND type == 1.
  - On a miss both hit outputs are 0 and IF_btb_target is 0.
- PHT index = IF_pc[PHT_IDX_W+1:2] XOR GHR. IF_pht_idx presents this value. IF_gbc_predict_taken = PHT[idx][1]. The prediction is produced regardless of BTB hit; the controller gates it with the hit.
- All updates happen on the rising clk edge. Lookups in the same cycle see the pre-update contents: no write-to-read bypass.
- EX_is_branch = 1:
  - PHT[EX_pht_idx] saturates: increment if taken (max 2'b11), decrement if not taken (min 2'b00).
  - GHR <= {GHR[PHT_IDX_W-2:0], EX_actual_taken}.
  - If taken: the BTB entry for EX_pc is written with valid = 1, the EX_pc tag, EX_target and type = 0, replacing any alias.
  - If not taken: the BTB is unchanged.
  - perf_branch_cnt increments. perf_mispredict_cnt increments when EX_predict_taken != EX_actual_taken.
  - Both counters wrap at 2^32.
- EX_is_jal = 1: the BTB entry is written with type = 1 and EX_target. The PHT, GHR and perf counters are unchanged.
- EX_is_branch and EX_is_jal both 1 is illegal. In that case EX_is_branch takes priority.
- GHR is non-speculative: it is updated only at EX resolution. Stalls need no input, because stalled or flushed slots reach EX as bubbles.
- Reset (rst low, asynchronous, any time including mid-update):
  - all BTB valid bits = 0 and targets = 0
  - every PHT counter = 2'b01 (weakly not-taken)
  - GHR = 0
  - both perf counters = 0
  - outputs settle to: hits 0, target 0, predict_taken 0, IF_pht_idx = IF_pc[PHT_IDX_W+1:2]
  - a write pending in the cycle of reset is discarded.
- Latency: lookup 0 cycles. A training update is visible to lookups on the cycle after the EX edge.

Test Plan:
- Reset, then IF_pc 0x00000100 -> b_hit 0, j_hit 0, target 0, predict_taken 0, IF_pht_idx 0x00.
- EX branch at 0x100 taken to 0x80 with EX_pht_idx 0x00 -> next cycle IF_pc 0x100 gives b_hit 1, target 0x80, GHR 0x01, IF_pht_idx 0x01, predict_taken 0 (PHT[0x01] still 01); PHT[0x00] = 10.
- Four taken updates on EX_pht_idx 0x05, then one not-taken -> counter 01→10→11→11→11→10; predict 1 throughout after the first update; GHR equals the last six outcomes.
- EX JAL at 0x200 to 0x400 -> IF_pc 0x200 gives j_hit 1, b_hit 0, target 0x400; GHR and perf counters unchanged.
- Alias: taken branch at 0x100 (target 0x80), then taken branch at 0x140 (target 0xC0), same index 0 -> IF_pc 0x100 misses, IF_pc 0x140 hits with 0xC0. Same-cycle lookup of the written index returns the old entry.
- Eight branches, three with EX_predict_taken != EX_actual_taken -> perf_branch_cnt 8, perf_mispredict_cnt 3. Assert rst low for one cycle mid-sequence with an update pending -> all counters 0, BTB empty, and the pending update is lost.
